// File: rtl/game_ctrl_fsm.sv
// Game flow controller: idle, play, hit / level-clear pauses, and win/lose screens.
// Tracks lives, level and a saturating score; every output is registered.
module game_ctrl_fsm #(
  parameter int LIVES        = 3,
  parameter int LEVELS       = 4,
  parameter int SCORE_W      = 16,
  parameter int PAUSE_FRAMES = 60,
  parameter int BONUS        = 100
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               user_input,
  input  logic               collided,
  input  logic               reached_screen_end,
  output logic [2:0]         state,
  output logic [2:0]         lives,
  output logic [2:0]         level,
  output logic [SCORE_W-1:0] score,
  output logic               play_en,
  output logic               level_start,
  output logic               show_lost,
  output logic               show_won
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_PLAY        = 3'd1,
    S_HIT         = 3'd2,
    S_LEVEL_CLEAR = 3'd3,
    S_GAME_OVER   = 3'd4,
    S_GAME_WON    = 3'd5
  } state_t;

  localparam int          PW         = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
  localparam logic [2:0]  LIVES_INIT = 3'(LIVES);
  localparam logic [2:0]  LAST_LEVEL = 3'(LEVELS - 1);
  localparam logic [PW-1:0] PAUSE_LAST = PW'(PAUSE_FRAMES - 1);

  state_t              cur, nxt;
  logic [2:0]          lives_n, level_n;
  logic [SCORE_W-1:0]  score_n;
  logic [PW-1:0]       pause_cnt, pause_n;
  logic                user_input_q;
  logic                press;

  assign press = user_input & ~user_input_q;
  assign state = cur;

  // Any carry out of the score width clamps to all-ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [31:0] b);
    logic [SCORE_W+32:0] s;
    s = {33'd0, a} + {{(SCORE_W + 1){1'b0}}, b};
    if (|s[SCORE_W+32:SCORE_W]) return '1;
    return s[SCORE_W-1:0];
  endfunction

  always_comb begin
    nxt     = cur;
    lives_n = lives;
    level_n = level;
    score_n = score;
    pause_n = pause_cnt;
    case (cur)
      S_IDLE: begin
        if (press) begin
          nxt     = S_PLAY;
          lives_n = LIVES_INIT;
          level_n = 3'd0;
          score_n = '0;
        end
      end
      S_PLAY: begin
        if (collided) begin
          pause_n = '0;
          if (lives <= 3'd1) begin
            nxt     = S_GAME_OVER;
            lives_n = 3'd0;
          end else begin
            nxt     = S_HIT;
            lives_n = lives - 3'd1;
          end
        end else if (reached_screen_end) begin
          pause_n = '0;
          score_n = sat_add(score, 32'(BONUS));
          nxt     = (level == LAST_LEVEL) ? S_GAME_WON : S_LEVEL_CLEAR;
        end else if (frame_tick) begin
          score_n = sat_add(score, 32'd1);
        end
      end
      S_HIT, S_LEVEL_CLEAR: begin
        // The counter sits one below the tick count, so the last tick exits.
        if (frame_tick) begin
          if (pause_cnt == PAUSE_LAST) begin
            nxt = S_PLAY;
            if (cur == S_LEVEL_CLEAR) level_n = level + 3'd1;
          end else begin
            pause_n = pause_cnt + PW'(1);
          end
        end
      end
      S_GAME_OVER, S_GAME_WON: begin
        if (press) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur          <= S_IDLE;
      lives        <= LIVES_INIT;
      level        <= 3'd0;
      score        <= '0;
      pause_cnt    <= '0;
      user_input_q <= 1'b0;
      play_en      <= 1'b0;
      level_start  <= 1'b0;
      show_lost    <= 1'b0;
      show_won     <= 1'b0;
    end else begin
      cur          <= nxt;
      lives        <= lives_n;
      level        <= level_n;
      score        <= score_n;
      pause_cnt    <= pause_n;
      user_input_q <= user_input;
      play_en      <= (nxt == S_PLAY);
      level_start  <= (nxt == S_PLAY) && (cur != S_PLAY);
      show_lost    <= (nxt == S_GAME_OVER);
      show_won     <= (nxt == S_GAME_WON);
    end
  end

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Scoreboard bench for game_ctrl_fsm: a rule-level model predicts a snapshot of
// every output after each clock edge; a monitor compares on the falling edge.
module tb_game_ctrl_fsm;

  localparam int LIVES = 3, LEVELS = 4, SCORE_W = 16, PAUSE_FRAMES = 2, BONUS = 100;
  localparam int MAX_SCORE = (1 << SCORE_W) - 1;
  localparam int W = 3 + 3 + 3 + SCORE_W + 4;

  logic clock = 1'b0, reset = 1'b1;
  logic frame_tick = 1'b0, user_input = 1'b0, collided = 1'b0, reached_screen_end = 1'b0;
  logic [2:0] state, lives, level;
  logic [SCORE_W-1:0] score;
  logic play_en, level_start, show_lost, show_won;

  game_ctrl_fsm #(
    .LIVES(LIVES), .LEVELS(LEVELS), .SCORE_W(SCORE_W),
    .PAUSE_FRAMES(PAUSE_FRAMES), .BONUS(BONUS)
  ) dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .user_input(user_input),
    .collided(collided), .reached_screen_end(reached_screen_end),
    .state(state), .lives(lives), .level(level), .score(score),
    .play_en(play_en), .level_start(level_start), .show_lost(show_lost), .show_won(show_won)
  );

  // clock / reset
  always #5 clock = ~clock;

  // reference model: game rules on plain integers
  int m_st = 0, m_lives = LIVES, m_level = 0, m_score = 0, m_pause = 0;
  bit m_prev = 0, m_ls = 0;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0, n_fail = 0, cyc = 0;

  task automatic model_step(input bit t, input bit u, input bit c, input bit r, input bit rs);
    bit pr;
    m_ls = 0;
    if (rs) begin
      m_st = 0; m_lives = LIVES; m_level = 0; m_score = 0; m_pause = 0; m_prev = 0;
      return;
    end
    pr = u && !m_prev;
    m_prev = u;
    case (m_st)
      0: if (pr) begin m_st = 1; m_lives = LIVES; m_level = 0; m_score = 0; m_ls = 1; end
      1: begin
        if (c) begin
          m_lives = m_lives - 1;
          m_st = (m_lives == 0) ? 4 : 2;
          m_pause = 0;
        end else if (r) begin
          m_score = (m_score + BONUS > MAX_SCORE) ? MAX_SCORE : m_score + BONUS;
          m_st = (m_level == LEVELS - 1) ? 5 : 3;
          m_pause = 0;
        end else if (t) begin
          m_score = (m_score + 1 > MAX_SCORE) ? MAX_SCORE : m_score + 1;
        end
      end
      2, 3: if (t) begin
        m_pause++;
        if (m_pause == PAUSE_FRAMES) begin
          if (m_st == 3) m_level++;
          m_st = 1; m_ls = 1;
        end
      end
      default: if (pr) m_st = 0;
    endcase
  endtask

  function automatic logic [W-1:0] model_snapshot();
    return {3'(m_st), 3'(m_lives), 3'(m_level), SCORE_W'(m_score),
            m_st == 1, m_ls, m_st == 4, m_st == 5};
  endfunction

  // driver: apply inputs, clock once, predict the post-edge outputs
  task automatic step(input bit t, input bit u, input bit c, input bit r, input bit rs);
    frame_tick = t; user_input = u; collided = c; reached_screen_end = r; reset = rs;
    @(posedge clock);
    model_step(t, u, c, r, rs);
    exp_q.push_back(model_snapshot());
    #1;
  endtask

  task automatic idle_cycles(input int n, input bit u);
    for (int i = 0; i < n; i++) step(0, u, 0, 0, 0);
  endtask

  task automatic press_btn();
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask

  // monitor / scoreboard: every cycle presents a full output snapshot
  always @(negedge clock) begin
    logic [W-1:0] got, exp;
    cyc++;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {state, lives, level, score, play_en, level_start, show_lost, show_won};
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL snapshot cyc=%0d got st=%0d lv=%0d lvl=%0d sc=%0d pe/ls/lost/won=%b exp st=%0d lv=%0d lvl=%0d sc=%0d pe/ls/lost/won=%b",
                 cyc, got[W-1 -: 3], got[W-4 -: 3], got[W-7 -: 3], got[SCORE_W+3:4], got[3:0],
                 exp[W-1 -: 3], exp[W-4 -: 3], exp[W-7 -: 3], exp[SCORE_W+3:4], exp[3:0]);
      end
    end
  end

  initial begin
    int bound;
    // reset state
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    idle_cycles(2, 0);

    // start game, score a few frames
    press_btn();
    idle_cycles(1, 0);
    ticks(5);

    // collision wins over screen end, then pause back to PLAY
    step(0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0);
    idle_cycles(1, 0);
    step(1, 0, 0, 0, 0);
    idle_cycles(2, 0);

    // clear every level without ticks in PLAY
    step(0, 0, 0, 0, 1);
    press_btn();
    for (int l = 0; l < LEVELS; l++) begin
      step(0, 0, 0, 1, 0);
      if (l < LEVELS - 1) ticks(PAUSE_FRAMES);
      idle_cycles(1, 0);
    end

    // back to IDLE, new game, lose every life, held button leaves game-over once
    press_btn();
    press_btn();
    for (int k = 0; k < LIVES; k++) begin
      step(1, 0, 1, 0, 0);
      if (k < LIVES - 1) ticks(PAUSE_FRAMES);
    end
    idle_cycles(10, 1);
    idle_cycles(2, 0);

    // score saturation
    press_btn();
    ticks(65500);
    step(0, 0, 0, 1, 0);
    ticks(PAUSE_FRAMES);
    ticks(4);

    // reset mid-pause
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    idle_cycles(2, 0);

    // reset released with the button already held
    step(0, 1, 0, 0, 1);
    idle_cycles(3, 1);
    idle_cycles(1, 0);

    // randomized play
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 249) == 0);
    idle_cycles(1, 0);

    bound = 0;
    while (exp_q.size() > 0 && bound < 10) begin
      @(posedge clock);
      bound++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d snapshots left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/game_ctrl_fsm.md
GAME_CTRL_FSM -- requirements
Module: game_ctrl_fsm

Interface
REQ-001 SHALL have parameter LIVES, default 3, lives per game (1..7).
REQ-002 SHALL have parameter LEVELS, default 4, levels per game (1..8).
REQ-003 SHALL have parameter SCORE_W, default 16, score register width.
REQ-004 SHALL have parameter PAUSE_FRAMES, default 60, frame ticks spent in HIT / LEVEL_CLEAR (>=1).
REQ-005 SHALL have parameter BONUS, default 100, score added on level clear.
REQ-006 SHALL have port clock  in  1  system clock, all logic on rising edge.
REQ-007 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port frame_tick  in  1  one-cycle pulse per video frame.
REQ-009 SHALL have port user_input  in  1  level, high while player presses button.
REQ-010 SHALL have port collided  in  1  level, player overlaps obstacle.
REQ-011 SHALL have port reached_screen_end  in  1  level, player at right edge.
REQ-012 SHALL have port state  out  3  current state encoding per REQ-014.
REQ-013 SHALL have ports lives out 3, level out 3, score out SCORE_W, play_en out 1, level_start out 1, show_lost out 1, show_won out 1; all registered.

Function
REQ-014 States: IDLE=0, PLAY=1, HIT=2, LEVEL_CLEAR=3, GAME_OVER=4, GAME_WON=5; codes 6/7 SHALL go to IDLE next cycle.
REQ-015 press = user_input & ~user_input_q (registered rising edge); held button SHALL NOT retrigger.
REQ-016 IDLE: press -> PLAY; same edge load lives=LIVES, level=0, score=0, pulse level_start.
REQ-017 PLAY: collided has priority over reached_screen_end when both high.
REQ-018 PLAY + collided: lives==1 -> GAME_OVER with lives=0; else HIT with lives-1.
REQ-019 PLAY + reached_screen_end (no collided): level==LEVELS-1 -> GAME_WON; else LEVEL_CLEAR; both add BONUS to score.
REQ-020 PLAY with no exit event: each frame_tick adds 1 to score.
REQ-021 Score additions SHALL saturate at 2^SCORE_W-1, never wrap.
REQ-022 HIT/LEVEL_CLEAR: pause counter cleared on entry, increments per frame_tick; at PAUSE_FRAMES ticks -> PLAY and pulse level_start.
REQ-023 LEVEL_CLEAR exit SHALL increment level; HIT exit SHALL keep level.
REQ-024 frame_tick in PLAY SHALL NOT count toward pause; frame_tick on the entry cycle to HIT/LEVEL_CLEAR SHALL NOT count.
REQ-025 GAME_OVER/GAME_WON: press -> IDLE; lives/level/score hold until next IDLE exit.
REQ-026 play_en=1 iff state==PLAY; show_lost=1 iff GAME_OVER; show_won=1 iff GAME_WON; outputs reflect current registered state.
REQ-027 level_start SHALL be exactly one cycle wide, asserted the cycle state first reads PLAY.
REQ-028 collided/reached_screen_end SHALL be ignored outside PLAY; user_input ignored outside IDLE/GAME_OVER/GAME_WON.

Reset
REQ-029 reset high at a clock edge SHALL force state=IDLE, lives=LIVES, level=0, score=0, pause counter=0, user_input_q=0, all single-bit outputs 0.
REQ-030 reset SHALL take priority over every transition, including mid-pause and mid-PLAY.
REQ-031 After reset release with user_input already high, press SHALL fire one cycle later (user_input_q=0 after reset).

Verification (LIVES=3, LEVELS=4, PAUSE_FRAMES=2, BONUS=100, SCORE_W=16)
REQ-032 Reset, pulse user_input 1 cycle -> state 1, lives 3, level 0, score 0, level_start one cycle; 5 frame_ticks -> score 5.
REQ-033 In PLAY assert collided and reached_screen_end same cycle -> state 2, lives 2, score unchanged; 2 frame_ticks -> state 1, level 0, level_start pulse.
REQ-034 Clear levels 0..3 via reached_screen_end, no ticks in PLAY -> score 400, final state 5, show_won=1, level 3.
REQ-035 Three collisions -> lives 2,1,0; third -> state 4, show_lost=1; hold user_input high 10 cycles -> single IDLE transition, stays IDLE.
REQ-036 Preload score 65500 via ticks, then level clear -> score 65535 (saturate); further ticks keep 65535.
REQ-037 Assert reset during HIT after 1 frame_tick -> next cycle state 0, lives 3, score 0, play_en 0.
